// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage: the upstream (in*) and
// downstream (out*) valid/ready/data channels seen by the stage register.
interface pipe_stage_reg_if #(
   parameter int WIDTH = 16
);
   logic             inValid;
   logic             inReady;
   logic [WIDTH-1:0] inData;
   logic             outValid;
   logic             outReady;
   logic [WIDTH-1:0] outData;

   // The stage register itself.
   modport slave (
      input  inValid, inData, outReady,
      output inReady, outValid, outData
   );

   // The surrounding datapath: the producer and the consumer of the stage.
   modport master (
      output inValid, inData, outReady,
      input  inReady, outValid, outData
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, local stall and flush,
// and an optional skid entry. With SKID=1 the stage holds up to two entries
// so that inReady comes from state only and throughput stays at one per cycle.
// With SKID=0 it is a single entry and inReady looks through to outReady.
module pipe_stage_reg #(
   parameter int               WIDTH       = 16,
   parameter int               SKID        = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   pipe_stage_reg_if.slave bus,
   output logic [1:0]      count
);

   logic             mainValid;
   logic             skidValid;
   logic [WIDTH-1:0] mainData;
   logic [WIDTH-1:0] skidData;

   logic             inReadyInt;
   logic             accept;
   logic             drain;

   logic             mainValidNxt;
   logic             skidValidNxt;
   logic             mainLoadIn;
   logic             mainLoadSkid;
   logic             skidLoadIn;

   // Upstream ready: from the skid occupancy alone, or looking through to outReady without a skid.
   always_comb begin
      if (SKID != 0) begin
         inReadyInt = !skidValid && !flush;
      end else begin
         inReadyInt = (!mainValid || bus.outReady) && !flush;
      end
   end

   assign accept       = bus.inValid && inReadyInt;
   assign drain        = mainValid && bus.outReady;

   assign bus.inReady  = inReadyInt;
   assign bus.outValid = mainValid;
   assign bus.outData  = mainData;

   // Next occupancy and which register loads what on this edge.
   always_comb begin
      // NOTE: every output of this block gets a default first so that no path leaves it unassigned (no latch).
      mainValidNxt = mainValid;
      skidValidNxt = skidValid;
      mainLoadIn   = 1'b0;
      mainLoadSkid = 1'b0;
      skidLoadIn   = 1'b0;
      if (flush) begin
         mainValidNxt = 1'b0;
         skidValidNxt = 1'b0;
      end else if (!mainValid || drain) begin
         if (skidValid) begin
            // inReady is low while the skid is full, so no accept competes here.
            mainValidNxt = 1'b1;
            skidValidNxt = 1'b0;
            mainLoadSkid = 1'b1;
         end else if (accept) begin
            mainValidNxt = 1'b1;
            mainLoadIn   = 1'b1;
         end else begin
            mainValidNxt = 1'b0;
         end
      end else if (accept && (SKID != 0)) begin
         // Main is stalled: park the new entry behind it.
         skidValidNxt = 1'b1;
         skidLoadIn   = 1'b1;
      end
   end

   // State update: reset dominates flush, which dominates the handshakes.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is written with non-blocking assignments only, so all registers update together.
      if (reset) begin
         mainValid <= 1'b0;
         skidValid <= 1'b0;
         count     <= 2'd0;
         // NOTE: the data registers are reset too, so outData shows RESET_VALUE right after reset.
         mainData  <= RESET_VALUE;
         skidData  <= RESET_VALUE;
      end else begin
         mainValid <= mainValidNxt;
         skidValid <= skidValidNxt;
         count     <= {1'b0, mainValidNxt} + {1'b0, skidValidNxt};
         if (mainLoadSkid) begin
            mainData <= skidData;
         end else if (mainLoadIn) begin
            mainData <= bus.inData;
         end
         if (skidLoadIn) begin
            skidData <= bus.inData;
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vectors on a SKID=1 and a SKID=0
// instance, followed by a random ready/valid run checked against a
// two-entry FIFO model on both instances.
module tb_pipe_stage_reg;

   localparam int WIDTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Per-instance stimulus (index 0: SKID=1, index 1: SKID=0).
   logic             rst       [2];
   logic             fl        [2];
   logic             in_valid  [2];
   logic [WIDTH-1:0] in_data   [2];
   logic             out_ready [2];

   logic             in_ready_w  [2];
   logic             out_valid_w [2];
   logic [WIDTH-1:0] out_data_w  [2];
   logic [1:0]       cnt_w       [2];

   pipe_stage_reg_if #(.WIDTH(WIDTH)) bus0 ();
   pipe_stage_reg_if #(.WIDTH(WIDTH)) bus1 ();

   assign bus0.inValid  = in_valid[0];
   assign bus0.inData   = in_data[0];
   assign bus0.outReady = out_ready[0];
   assign bus1.inValid  = in_valid[1];
   assign bus1.inData   = in_data[1];
   assign bus1.outReady = out_ready[1];

   assign in_ready_w[0]  = bus0.inReady;
   assign out_valid_w[0] = bus0.outValid;
   assign out_data_w[0]  = bus0.outData;
   assign in_ready_w[1]  = bus1.inReady;
   assign out_valid_w[1] = bus1.outValid;
   assign out_data_w[1]  = bus1.outData;

   pipe_stage_reg #(.WIDTH(WIDTH), .SKID(1), .RESET_VALUE('0)) u_skid (
      .clk   (clk),
      .reset (rst[0]),
      .flush (fl[0]),
      .bus   (bus0),
      .count (cnt_w[0])
   );

   pipe_stage_reg #(.WIDTH(WIDTH), .SKID(0), .RESET_VALUE('0)) u_noskid (
      .clk   (clk),
      .reset (rst[1]),
      .flush (fl[1]),
      .bus   (bus1),
      .count (cnt_w[1])
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int               dut;
      bit               rst;
      bit               fl;
      bit               iv;
      logic [WIDTH-1:0] id;
      bit               ordy;
      bit               chk_rdy;
      bit               exp_rdy;   // inReady before the edge
      bit               exp_ov;    // outValid after the edge
      logic [WIDTH-1:0] exp_data;  // outData after the edge
      bit               chk_data;
      logic [1:0]       exp_cnt;   // count after the edge
   } vec_t;

   function automatic vec_t mk(input int d, input bit r, input bit f, input bit iv,
                               input logic [WIDTH-1:0] id, input bit ordy,
                               input bit chk_rdy, input bit exp_rdy, input bit exp_ov,
                               input logic [WIDTH-1:0] exp_data, input bit chk_data,
                               input logic [1:0] exp_cnt);
      vec_t v;
      v.dut = d; v.rst = r; v.fl = f; v.iv = iv; v.id = id; v.ordy = ordy;
      v.chk_rdy = chk_rdy; v.exp_rdy = exp_rdy; v.exp_ov = exp_ov;
      v.exp_data = exp_data; v.chk_data = chk_data; v.exp_cnt = exp_cnt;
      return v;
   endfunction

   // Drive one vector, check inReady before the edge and the state after it.
   task automatic apply(input vec_t v, input int idx);
      int d;
      d            = v.dut;
      rst[d]       = v.rst;
      fl[d]        = v.fl;
      in_valid[d]  = v.iv;
      in_data[d]   = v.id;
      out_ready[d] = v.ordy;
      @(negedge clk);
      if (v.chk_rdy) check($sformatf("vec%0d_inReady", idx), in_ready_w[d], v.exp_rdy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_outValid", idx), out_valid_w[d], v.exp_ov);
      check($sformatf("vec%0d_count", idx), cnt_w[d], v.exp_cnt);
      if (v.chk_data) check($sformatf("vec%0d_outData", idx), out_data_w[d], v.exp_data);
   endtask

   // Random-phase reference: up to two queued entries per instance.
   logic [WIDTH-1:0] mdl   [2][2];
   int               msize [2];
   bit               acc   [2];
   bit               drn   [2];

   initial begin
      vec_t vecs [$];
      int   lim;
      bit   exp_rdy;

      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b0; fl[d] = 1'b0; in_valid[d] = 1'b0;
         in_data[d] = '0; out_ready[d] = 1'b0; msize[d] = 0;
      end

      // ---- SKID=1: reset, then stream 1..8 with outReady=1 ----
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 2'd0));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 1, 1, 0, 16'h0000, 1, 2'd0));
      for (int k = 1; k <= 8; k++)
         vecs.push_back(mk(0, 0, 0, 1, WIDTH'(k), 1, 1, 1, 1, WIDTH'(k), 1, 2'd1));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0008, 0, 2'd0));
      // ---- SKID=1: backpressure fill and release ----
      vecs.push_back(mk(0, 0, 0, 1, 16'hA5A5, 0, 1, 1, 1, 16'hA5A5, 1, 2'd1));
      vecs.push_back(mk(0, 0, 0, 1, 16'h5A5A, 0, 1, 1, 1, 16'hA5A5, 1, 2'd2));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 1, 16'hA5A5, 1, 2'd2));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 0, 1, 16'h5A5A, 1, 2'd1));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h5A5A, 0, 2'd0));
      // ---- SKID=1: flush while full with input offered ----
      vecs.push_back(mk(0, 0, 0, 1, 16'h1111, 0, 1, 1, 1, 16'h1111, 1, 2'd1));
      vecs.push_back(mk(0, 0, 0, 1, 16'h2222, 0, 1, 1, 1, 16'h1111, 1, 2'd2));
      vecs.push_back(mk(0, 0, 1, 1, 16'hBEEF, 0, 1, 0, 0, 16'h1111, 1, 2'd0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h1111, 1, 2'd0));
      // ---- SKID=1: flush together with a drain ----
      vecs.push_back(mk(0, 0, 0, 1, 16'h3333, 0, 1, 1, 1, 16'h3333, 1, 2'd1));
      vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 1, 0, 0, 16'h3333, 1, 2'd0));
      // ---- SKID=1: reset while full ----
      vecs.push_back(mk(0, 0, 0, 1, 16'h4444, 0, 1, 1, 1, 16'h4444, 1, 2'd1));
      vecs.push_back(mk(0, 0, 0, 1, 16'h5555, 0, 1, 1, 1, 16'h4444, 1, 2'd2));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 2'd0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 16'h0000, 1, 2'd0));
      // ---- SKID=0: stall, same-cycle drain+accept, flush, reset ----
      vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 2'd0));
      vecs.push_back(mk(1, 0, 0, 1, 16'h00AA, 0, 1, 1, 1, 16'h00AA, 1, 2'd1));
      vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h00AA, 1, 2'd1));
      vecs.push_back(mk(1, 0, 0, 1, 16'h1234, 1, 1, 1, 1, 16'h1234, 1, 2'd1));
      vecs.push_back(mk(1, 0, 0, 1, 16'h5678, 0, 1, 0, 1, 16'h1234, 1, 2'd1));
      vecs.push_back(mk(1, 0, 0, 1, 16'h5678, 1, 1, 1, 1, 16'h5678, 1, 2'd1));
      vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h5678, 0, 2'd0));
      vecs.push_back(mk(1, 0, 0, 1, 16'h9999, 0, 1, 1, 1, 16'h9999, 1, 2'd1));
      vecs.push_back(mk(1, 0, 1, 1, 16'hBEEF, 1, 1, 0, 0, 16'h9999, 1, 2'd0));
      vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 16'h9999, 1, 2'd0));
      vecs.push_back(mk(1, 0, 0, 1, 16'h4242, 0, 1, 1, 1, 16'h4242, 1, 2'd1));
      vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 2'd0));

      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // ---- Random ready/valid on both instances against the FIFO model ----
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; fl[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b0; msize[d] = 0;
      end

      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            lim = (d == 0) ? 2 : 1;
            if (fl[d])       exp_rdy = 1'b0;
            else if (d == 0) exp_rdy = (msize[d] < 2);
            else             exp_rdy = (msize[d] == 0) || out_ready[d];
            if (!rst[d]) begin
               check($sformatf("rnd%0d_c%0d_inReady", d, cyc), in_ready_w[d], exp_rdy);
               check($sformatf("rnd%0d_c%0d_outValid", d, cyc), out_valid_w[d], msize[d] > 0);
               check($sformatf("rnd%0d_c%0d_count", d, cyc), cnt_w[d], msize[d]);
               check($sformatf("rnd%0d_c%0d_bound", d, cyc), 32'(cnt_w[d]) <= 32'(lim), 1'b1);
               if (msize[d] > 0)
                  check($sformatf("rnd%0d_c%0d_outData", d, cyc), out_data_w[d], mdl[d][0]);
            end
            acc[d] = in_valid[d] && exp_rdy;
            drn[d] = out_ready[d] && (msize[d] > 0);
         end
         @(posedge clk);
         for (int d = 0; d < 2; d++) begin
            if (rst[d] || fl[d]) begin
               msize[d] = 0;
            end else begin
               if (drn[d]) begin
                  mdl[d][0] = mdl[d][1];
                  msize[d]--;
               end
               if (acc[d]) begin
                  mdl[d][msize[d]] = in_data[d];
                  msize[d]++;
               end
            end
         end
         #1;
         for (int d = 0; d < 2; d++) begin
            if (rst[d] || !(in_valid[d] && !acc[d])) begin
               in_valid[d] = ($urandom_range(0, 2) != 0);
               in_data[d]  = WIDTH'($urandom);
            end
            rst[d]       = ($urandom_range(0, 999) == 0);
            fl[d]        = ($urandom_range(0, 49) == 0);
            out_ready[d] = ($urandom_range(0, 2) != 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the plain pipeline register: a WIDTH-bit stage register with valid/ready handshake, stall (backpressure), flush, and an optional skid entry.
- Sits between the stages of the three-stage datapath (fetch/decode -> execute -> writeback).
- Stalls and branch flushes are handled locally, so no global enable fan-out is needed.

Parameters:
- WIDTH, 16, payload bit-width.
- SKID, 1, 1 = two-entry stage (main + skid) giving full throughput with a registered inReady; 0 = single entry with combinational inReady.
- RESET_VALUE, '0, value loaded into all data registers on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous kill of all held entries.
- inValid  input  1  upstream data valid.
- inReady  output  1  stage can accept inData this cycle.
- inData  input  WIDTH  upstream payload.
- outValid  output  1  outData holds a valid entry.
- outReady  input  1  downstream accepts outData this cycle.
- outData  output  WIDTH  payload, driven directly from the main register.
- count  output  2  occupancy: 0..2 when SKID=1, 0..1 when SKID=0.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - On a clk edge with reset=1: mainValid=0, skidValid=0, main and skid data=RESET_VALUE.
  - After that edge: outValid=0, count=0, outData=RESET_VALUE, inReady=1 (if flush=0).
  - reset has priority over flush and over all handshakes. Reset mid-transfer drops every held entry.
- Handshake definitions:
  - accept = inValid & inReady.
  - drain = outValid & outReady.
  - inValid/inData must stay stable until accepted; the stage never depends on this, but verification checks it upstream.
- Latency: an entry accepted at edge N is presented on outData with outValid=1 after edge N; this is 1 cycle.
- Order: strict FIFO order; no entry is duplicated or dropped except by flush or reset.
- SKID=0:
  - inReady = (!outValid | outReady) & !flush.
  - On accept, main loads inData and mainValid=1.
  - On drain without accept, mainValid=0 and data is held.
- SKID=1:
  - inReady = !skidValid & !flush. This depends only on state and flush, never on outReady.
  - Main empty or draining:
    - If skidValid, main loads skid data and skidValid=0. No accept is possible in this case.
    - Otherwise, if accept, main loads inData.
    - Otherwise, mainValid=0.
  - Main valid and not draining:
    - If accept, skid loads inData and skidValid=1. Main is held.
  - Full (count=2): inReady=0, and both entries are held until outReady.
  - Sustained inValid=outReady=1 gives one transfer per cycle.
- Flush:
  - On an edge with flush=1 (reset=0), mainValid=0 and skidValid=0. Data registers keep their values.
  - inReady=0 during flush, so no input is accepted in that cycle.
  - A drain in the same cycle completes downstream; its entry is still consumed.
  - The cycle after flush: count=0 and inReady=1.
- count:
  - count = mainValid + skidValid, registered with the valids.
  - count never exceeds 2^SKID.
- outData while outValid=0: holds the last loaded value. It is not required to be meaningful.

Test Plan:
- Reset then stream, SKID=1: assert reset for 2 cycles, then send 0x0001..0x0008 with outReady=1 -> outValid=1 from the cycle after the first accept; outData=0x0001..0x0008 on consecutive cycles; count stays 1; inReady=1 throughout.
- Backpressure fill, SKID=1: send 0xA5A5 then 0x5A5A with outReady=0 -> count=2 and inReady=0; raise outReady -> 0xA5A5 then 0x5A5A on consecutive cycles; inReady=1 again once the skid empties.
- SKID=0 stall: hold outReady=0 with outValid=1 -> inReady=0 combinationally; raise outReady with inValid=1, inData=0x1234 -> same-cycle drain and accept; next cycle outData=0x1234.
- Flush with simultaneous input: count=2, then flush=1 with inValid=1, inData=0xBEEF -> inReady=0; next cycle count=0, outValid=0; 0xBEEF never appears.
- Reset mid-operation: count=2, then reset=1 and flush=0 -> next cycle outValid=0, count=0, outData=RESET_VALUE (0x0000).
- Random ready/valid, 10k cycles, both SKID values -> scoreboard shows FIFO order, no loss or duplication, count ≤ 2^SKID.
